// File: rtl/spi_fifo_controller.sv
// SPI master with byte-wide TX/RX FIFOs behind a 4-register bus port; config writes are shadowed until the engine idles.
// Define SPI_CRC16_EN to add a CRC16-CCITT accumulator over every transferred byte (CRC_HI/CRC_LO).
module spi_fifo_controller #(
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic [1:0]        addr,
  input  logic              r_w,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic              irq
);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]        r_ctrl, r_ctrl_sh;
  logic [7:0]        r_div, r_div_sh;
  logic [NUM_SS-1:0] r_sel, r_sel_sh;
  logic              r_tx_ovf;
  logic [7:0]        r_tx_mem [FIFO_DEPTH];
  logic [7:0]        r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [AW:0]       r_tx_cnt, r_rx_cnt;
  logic [7:0]        r_tx_sh, r_rx_sh, r_div_cnt;
  logic [3:0]        r_half;
  logic              r_sclk, r_mosi;

  logic       w_wr_data, w_rd_data, w_rd_stat;
  logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_busy;
  logic       w_start, w_tx_pop, w_tx_push, w_rx_pop, w_rx_push, w_half_end;
  logic [7:0] w_load_byte, w_rdata_nxt, w_crc_hi, w_crc_lo;

  assign w_wr_data  = acc & ~r_w & (addr == 2'd0);
  assign w_rd_data  = acc &  r_w & (addr == 2'd0);
  assign w_rd_stat  = acc &  r_w & (addr == 2'd1);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == DEPTH);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == DEPTH);
  assign w_busy     = (r_state != S_IDLE);

  // Start decisions use the shadow rx_en because it becomes active on this same edge.
  assign w_start     = (r_state == S_IDLE) & (~w_tx_empty | (r_ctrl_sh[2] & ~w_rx_full));
  assign w_tx_pop    = (r_state == S_IDLE) & ~w_tx_empty;
  assign w_load_byte = w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rp];
  assign w_tx_push   = w_wr_data & (~w_tx_full | w_tx_pop);
  assign w_rx_pop    = w_rd_data & ~w_rx_empty;
  assign w_rx_push   = (r_state == S_STORE) & r_ctrl[2] & (~w_rx_full | w_rx_pop);
  assign w_half_end  = (r_state == S_SHIFT) & (r_div_cnt == r_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_sh <= '0; r_div_sh <= '0; r_sel_sh <= '0;
      r_ctrl    <= '0; r_div    <= '0; r_sel    <= '0;
    end else begin
      if (acc && !r_w) begin
        case (addr)
          2'd1:    r_ctrl_sh <= wdata[3:0];
          2'd2:    r_div_sh  <= wdata;
          2'd3:    r_sel_sh  <= wdata[NUM_SS-1:0];
          default: ;
        endcase
      end
      if (r_state == S_IDLE) begin
        r_ctrl <= r_ctrl_sh;
        r_div  <= r_div_sh;
        r_sel  <= r_sel_sh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + (AW+1)'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - (AW+1)'(1);
        default: ;
      endcase
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + (AW+1)'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata_nxt = 8'h00;
    case (addr)
      2'd0:    w_rdata_nxt = w_rx_empty ? 8'hFF : r_rx_mem[r_rx_rp];
      2'd1:    w_rdata_nxt = {2'b00, r_tx_ovf, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty, w_busy};
      2'd2:    w_rdata_nxt = w_crc_hi;
      default: w_rdata_nxt = w_crc_lo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata    <= 8'h00;
      r_tx_ovf <= 1'b0;
    end else begin
      if (acc && r_w) rdata <= w_rdata_nxt;
      if (w_wr_data && w_tx_full && !w_tx_pop) r_tx_ovf <= 1'b1;
      else if (w_rd_stat)                      r_tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_half_end && r_half == 4'd15) w_state_nxt = S_STORE;
      S_STORE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Even half-periods end on a leading sclk edge, odd ones on a trailing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk <= 1'b0; r_mosi <= 1'b1; r_tx_sh <= '0; r_rx_sh <= '0;
      r_div_cnt <= '0; r_half <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sclk    <= r_ctrl[0];
          r_div_cnt <= '0;
          r_half    <= '0;
          if (w_start) begin
            r_tx_sh <= w_load_byte;
            if (!r_ctrl_sh[1]) r_mosi <= w_load_byte[7];
          end
        end
        S_LOAD: r_sclk <= r_ctrl[0];
        S_SHIFT: begin
          if (w_half_end) begin
            r_div_cnt <= '0;
            r_half    <= r_half + 4'd1;
            r_sclk    <= ~r_sclk;
            if (r_half[0] == r_ctrl[1]) begin
              r_rx_sh <= {r_rx_sh[6:0], miso};
            end else if (r_ctrl[1]) begin
              r_mosi  <= r_tx_sh[7];
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end else if (r_half != 4'd15) begin
              r_mosi  <= r_tx_sh[6];
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_CRC16_EN
  logic [15:0] r_crc;
  logic [7:0]  r_tx_byte;
  logic        w_crc_rst;

  assign w_crc_rst = acc & ~r_w & (addr == 2'd1) & wdata[7];

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] v;
    v = c;
    for (int i = 7; i >= 0; i--) v = {v[14:0], 1'b0} ^ ((v[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc     <= 16'hFFFF;
      r_tx_byte <= 8'h00;
    end else begin
      if (w_start) r_tx_byte <= w_load_byte;
      if (w_crc_rst)               r_crc <= 16'hFFFF;
      else if (r_state == S_STORE) r_crc <= crc_upd(r_crc, r_ctrl[2] ? r_rx_sh : r_tx_byte);
    end
  end

  assign w_crc_hi = r_crc[15:8];
  assign w_crc_lo = r_crc[7:0];
`else
  assign w_crc_hi = 8'h00;
  assign w_crc_lo = 8'h00;
`endif

  assign mosi = r_mosi;
  assign sclk = r_sclk;
  assign ss_n = ~r_sel;
  assign irq  = r_ctrl[3] & ((w_tx_empty & ~w_busy) | (r_ctrl[2] & ~w_rx_empty));

endmodule
